// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
package uart_pkg;

   localparam int unsigned DATA_BITS            = 8;
   localparam int unsigned DEFAULT_CLKS_PER_BIT = 10;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

endpackage

// File: rtl/tx_block_if.sv
// Byte handshake into the transmitter: upstream is master, tx_block is slave.
interface tx_block_if;
   import uart_pkg::*;

   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/tx_block_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, restarts on clear.
module tx_bit_timer
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic bit_end,
   output logic bit_pre_end
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable) begin
         if (bit_end) count <= '0;
         else         count <= count + 1'b1;
      end
   end

   assign bit_end     = (count == LAST);
   // Lets the registered tx_done line up with the final cycle of a bit.
   assign bit_pre_end = (count == PRE);

endmodule

// File: rtl/tx_block.sv
// UART transmitter: one-entry holding buffer feeding a start/8N/stop serializer.
module tx_block
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst,
   tx_block_if.slave  tx,
   output logic       serial_out,
   output logic       tx_busy,
   output logic       tx_done
);

   tx_state_t            state, state_next;
   logic [DATA_BITS-1:0] buf_data;
   logic                 buf_full;
   logic [DATA_BITS-1:0] shift_reg, shift_next;
   logic [2:0]           bit_idx, bit_idx_next;
   logic                 load;
   logic                 accept;
   logic                 serial_next;
   logic                 bit_end;
   logic                 bit_pre_end;

   assign tx.tx_ready = ~buf_full;
   assign accept      = tx.tx_valid & ~buf_full;

   tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk         (clk),
      .rst         (rst),
      .clear       (state_next != state),
      .enable      (state != IDLE),
      .bit_end     (bit_end),
      .bit_pre_end (bit_pre_end)
   );

   always_comb begin
      state_next   = state;
      shift_next   = shift_reg;
      bit_idx_next = bit_idx;
      load         = 1'b0;
      unique case (state)
         IDLE: begin
            if (buf_full) begin
               load       = 1'b1;
               state_next = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_next   = DATA;
               bit_idx_next = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_next = shift_reg >> 1;
               if (bit_idx == 3'd7) begin
                  state_next   = STOP;
                  bit_idx_next = '0;
               end else begin
                  bit_idx_next = bit_idx + 3'd1;
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               if (buf_full) begin
                  load       = 1'b1;
                  state_next = START;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
      if (load) shift_next = buf_data;

      // Line level is decoded from the next state so serial_out stays a flop.
      unique case (state_next)
         START:   serial_next = 1'b0;
         DATA:    serial_next = shift_next[0];
         default: serial_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         buf_data   <= '0;
         buf_full   <= 1'b0;
         shift_reg  <= '0;
         bit_idx    <= '0;
         serial_out <= 1'b1;
         tx_busy    <= 1'b0;
         tx_done    <= 1'b0;
      end else begin
         state      <= state_next;
         shift_reg  <= shift_next;
         bit_idx    <= bit_idx_next;
         serial_out <= serial_next;
         tx_busy    <= (state_next != IDLE);
         tx_done    <= (state == STOP) && bit_pre_end;
         if (accept) begin
            buf_data <= tx.tx_data;
            buf_full <= 1'b1;
         end else if (load) begin
            buf_full <= 1'b0;
         end
      end
   end

endmodule
